// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the five-stage MIPS pipeline. It holds the PC, drives the
// instruction-memory read address, and fills the IF/ID register. A bad PC puts the stage into a sticky fault.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        jumpEnabled,
  input  logic [31:0] jumpTarget,
  output logic [31:0] imAddress,
  input  logic [31:0] imData,
  output logic [31:0] idInstruction,
  output logic [31:0] idPc,
  output logic        idValid,
  output logic        fetchFault,
  output logic [31:0] fetchCount
);

  typedef enum logic {RUN, FAULT} state_e;

  // The range limit is kept at 33 bits, so a memory that ends at 2^32 does not wrap to zero.
  localparam logic [32:0] PC_BASE  = {1'b0, RESET_PC};
  localparam logic [32:0] PC_LIMIT = PC_BASE + (33'(IM_WORDS) << 2);

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] idInstruction_q;
  logic [31:0] idPc_q;
  logic        idValid_q;
  logic        fetchFault_q;
  logic [31:0] fetchCount_q;
  logic        pcBad;

  always_comb begin
    pcBad = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} < PC_BASE) || ({1'b0, pc_q} >= PC_LIMIT);
    pc_d  = pc_q;
    if (jumpEnabled) begin
      pc_d = jumpTarget;
    end else if (!pcBad) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // The stall check comes first, so a jump seen during a stall is dropped. Decode asserts the jump again after the stall ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= RUN;
      pc_q            <= RESET_PC;
      idInstruction_q <= 32'd0;
      idPc_q          <= 32'd0;
      idValid_q       <= 1'b0;
      fetchFault_q    <= 1'b0;
      fetchCount_q    <= 32'd0;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          pc_q <= pc_d;
          if (pcBad) begin
            idInstruction_q <= 32'd0;
            idPc_q          <= pc_q;
            idValid_q       <= 1'b0;
            fetchFault_q    <= 1'b1;
            state_q         <= FAULT;
          end else begin
            idInstruction_q <= imData;
            idPc_q          <= pc_q;
            idValid_q       <= 1'b1;
            fetchCount_q    <= fetchCount_q + 32'd1;
          end
        end
        FAULT: begin
          idInstruction_q <= 32'd0;
          idPc_q          <= pc_q;
          idValid_q       <= 1'b0;
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  assign imAddress     = pc_q;
  assign idInstruction = idInstruction_q;
  assign idPc          = idPc_q;
  assign idValid       = idValid_q;
  assign fetchFault    = fetchFault_q;
  assign fetchCount    = fetchCount_q;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the combinational instruction-memory read address, and registers the fetched word and its PC into the IF/ID pipeline register that feeds the decode stage's controller unit. It applies stall and jump redirects computed in decode with MIPS single-delay-slot semantics, and halts into a sticky fault state on a misaligned or out-of-range PC.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset; base of instruction memory.
- IM_WORDS, 1024: instruction memory size in words. The valid fetch range is [RESET_PC, RESET_PC + 4*IM_WORDS).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  from the hazard logic; holds the PC and IF/ID.
- jumpEnabled  in  1  from decode: the taken-jump/branch condition for the instruction in IF/ID.
- jumpTarget  in  32  from decode: the absolute target PC (near, far and relative targets are already resolved).
- imAddress  out  32  instruction-memory read address; combinational, equal to pc.
- imData  in  32  instruction word at imAddress; combinational read, valid in the same cycle.
- idInstruction  out  32  IF/ID instruction word.
- idPc  out  32  IF/ID PC of idInstruction; decode computes PC+8 links from it.
- idValid  out  1  IF/ID holds a real instruction. When it is 0, idInstruction is 0 (sll $0,$0,0 = NOP).
- fetchFault  out  1  sticky; set once a bad PC has been fetched.
- fetchCount  out  32  number of instructions delivered into IF/ID; wraps modulo 2^32.

## Operation

- States: RUN, FAULT (2-state FSM). Reset enters RUN.
- Bad PC: pc[1:0] != 0, or pc < RESET_PC, or pc >= RESET_PC + 4*IM_WORDS. Range arithmetic is 33-bit so the upper bound does not wrap.

RUN, at each edge with reset = 0:
- stall = 1:
  - pc, IF/ID, fetchCount and state hold.
  - jumpEnabled is ignored. Decode is stalled too and re-presents the jump once it is released.
- stall = 0, pc good:
  - IF/ID ← {imData, pc, valid = 1}.
  - fetchCount += 1.
  - pc ← jumpEnabled ? jumpTarget : pc + 4. The pc + 4 add wraps modulo 2^32.
- stall = 0, pc bad:
  - IF/ID ← bubble {0, pc, valid = 0}.
  - pc holds; fetchFault ← 1; state ← FAULT.
  - A jumpEnabled in this cycle is still honoured for pc only when the jump comes from the instruction in IF/ID. Rule: pc ← jumpEnabled ? jumpTarget : pc, so a valid jump out of a bad delay-slot address is not lost. The state still goes to FAULT.

FAULT:
- Each non-stalled edge loads a bubble into IF/ID.
- pc, fetchCount and fetchFault hold. jumpEnabled is ignored.
- Only reset leaves FAULT.

Delay slot:
- The instruction fetched in the same cycle that decode asserts jumpEnabled is the delay slot. It is always delivered; fetch never squashes.

## Timing

Reset values (after a reset edge):
- pc = RESET_PC; state = RUN.
- idInstruction = 0, idPc = 0, idValid = 0.
- fetchFault = 0, fetchCount = 0.
- Reset asserted during FAULT or during a stall clears everything the same way.

Latency and timing rules:
- imAddress follows pc combinationally with zero latency. Fetch-to-IF/ID latency is 1 cycle.
- Jump redirect: jumpEnabled sampled at edge N, with IF/ID holding instruction at P, causes:
  - edge N captures P+4, the delay slot;
  - edge N+1 captures jumpTarget.
  - No bubble is inserted.
- Stall has priority over jump. reset has priority over everything.
- fetchCount increments in exactly the cycles where idValid is loaded with 1.

## Test plan

- Reset, then 3 cycles with imData = word at address: idPc sequence 0x3000, 0x3004, 0x3008; idValid = 1; fetchCount = 3.
- stall = 1 for 2 cycles while IF/ID holds 0x3004: IF/ID and imAddress (0x3008) are unchanged, and fetchCount is unchanged. After release, idPc = 0x3008.
- jumpEnabled = 1 with jumpTarget = 0x3040 while idPc = 0x3008: next idPc = 0x300C (the delay slot), then 0x3040.
- stall = 1 and jumpEnabled = 1 in the same cycle: no redirect. With the stall released and jump re-asserted the next cycle, the delay slot is 0x300C, then the target.
- jumpTarget = 0x3042:
  - After the delay slot, the next edge gives idValid = 0, idInstruction = 0 and fetchFault = 1.
  - Later edges keep producing bubbles with imAddress held at 0x3042.
  - A reset restores pc = 0x3000 and fetchFault = 0.
- jumpTarget = RESET_PC + 4*IM_WORDS (0x4000) gives a fault. jumpTarget = 0x3FFC does not fault, and the next sequential fetch at 0x4000 faults.
